// File: rtl/move_sequencer_pkg.sv
// Shared encodings for the move sequencer: tile marks, turn bit, FSM states,
// and the per-entry layout of the undo history.
package move_sequencer_pkg;

  localparam int unsigned N_TILES = 9;
  localparam int unsigned IDX_W   = $clog2(N_TILES);

  typedef enum logic [1:0] {
    TILE_EMPTY = 2'b00,
    TILE_X     = 2'b01,
    TILE_O     = 2'b10
  } tile_t;

  localparam logic TURN_X = 1'b0;
  localparam logic TURN_O = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    UNDO
  } state_t;

  typedef struct packed {
    logic [2*N_TILES-1:0] board;
    logic                 turn;
  } hist_t;

  // Switches are wired with each row's columns reversed relative to tiles.
  function automatic int unsigned sw_to_tile(input int unsigned s);
    return 3 * (s / 3) + 2 - (s % 3);
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus stability counter for one raw input; emits a
// single-cycle pulse when the debounced level goes from 0 to 1.
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             prev;
  logic             level;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      prev  <= 1'b0;
      count <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      prev <= sync[1];
      rise <= 1'b0;
      if (sync[1] != prev) begin
        count <= '0;
      end else if (count != CNT_MAX) begin
        count <= count + CNT_W'(1);
      end else begin
        level <= sync[1];
        rise  <= sync[1] & ~level;
      end
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Turns debounced tile switches and the undo button into validated one-cycle
// move/undo commands, owning the turn bit and a circular undo history.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned STACK_DEPTH     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_TILES-1:0]           input_switches,
  input  logic                         undo_sig,
  input  logic [2*N_TILES-1:0]         tiles,
  input  logic                         game_over,
  output logic                         move_valid,
  output logic [N_TILES-1:0]           move_onehot,
  output logic                         move_turn,
  output logic                         undo_valid,
  output logic [2*N_TILES-1:0]         undo_tiles,
  output logic                         current_turn,
  output logic [$clog2(STACK_DEPTH):0] stack_count
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(STACK_DEPTH);

  logic [N_TILES-1:0] sw_rise;
  logic [N_TILES-1:0] tile_evt;
  logic [N_TILES-1:0] cand;
  logic [N_TILES-1:0] win_oh;
  logic [N_TILES-1:0] pend_vec;
  logic [IDX_W-1:0]   win_idx;
  logic               cand_any;
  logic               undo_rise;
  logic               pend_undo;
  logic               move_ok;
  logic               undo_ok;
  state_t             state;
  hist_t              hist [STACK_DEPTH];
  hist_t              head;
  logic [PTR_W-1:0]   wr_ptr;

  for (genvar s = 0; s < N_TILES; s++) begin : g_sw
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
      .clk   (clk),
      .reset (reset),
      .raw   (input_switches[s]),
      .rise  (sw_rise[s])
    );
  end

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_undo (
    .clk   (clk),
    .reset (reset),
    .raw   (undo_sig),
    .rise  (undo_rise)
  );

  always_comb begin
    tile_evt = '0;
    for (int unsigned s = 0; s < N_TILES; s++) begin
      tile_evt[sw_to_tile(s)] = sw_rise[s];
    end
  end

  // pend_vec is only non-zero in IDLE, so during COMMIT/UNDO the winner is
  // drawn from fresh events alone and becomes the held request.
  always_comb begin
    cand     = tile_evt | pend_vec;
    cand_any = |cand;
    win_idx  = '0;
    for (int unsigned t = 0; t < N_TILES; t++) begin
      if (cand[t]) win_idx = IDX_W'(t);
    end
    win_oh = '0;
    if (cand_any) win_oh[win_idx] = 1'b1;
  end

  assign head    = hist[wr_ptr - PTR_W'(1)];
  assign undo_ok = (undo_rise | pend_undo) && (stack_count != '0);
  assign move_ok = cand_any && !game_over && (tiles[2*win_idx +: 2] == TILE_EMPTY);

  always_ff @(posedge clk) begin
    if (state == COMMIT) hist[wr_ptr] <= '{board: tiles, turn: current_turn};
  end

  // Stack pointer, count and turn change only on leaving COMMIT/UNDO, so a
  // reset during the pulse leaves no partial push or pop behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      move_valid   <= 1'b0;
      move_onehot  <= '0;
      move_turn    <= TURN_X;
      undo_valid   <= 1'b0;
      undo_tiles   <= '0;
      current_turn <= TURN_X;
      stack_count  <= '0;
      wr_ptr       <= '0;
      pend_vec     <= '0;
      pend_undo    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pend_vec  <= '0;
          pend_undo <= 1'b0;
          if (undo_ok) begin
            state      <= UNDO;
            undo_valid <= 1'b1;
            undo_tiles <= head.board;
          end else if (move_ok) begin
            state       <= COMMIT;
            move_valid  <= 1'b1;
            move_onehot <= win_oh;
            move_turn   <= current_turn;
          end
        end
        COMMIT: begin
          state        <= IDLE;
          move_valid   <= 1'b0;
          move_onehot  <= '0;
          move_turn    <= TURN_X;
          wr_ptr       <= wr_ptr + PTR_W'(1);
          current_turn <= (current_turn == TURN_X) ? TURN_O : TURN_X;
          if (stack_count != COUNT_FULL) stack_count <= stack_count + CNT_W'(1);
          pend_vec     <= win_oh;
          pend_undo    <= undo_rise;
        end
        UNDO: begin
          state        <= IDLE;
          undo_valid   <= 1'b0;
          undo_tiles   <= '0;
          wr_ptr       <= wr_ptr - PTR_W'(1);
          stack_count  <= stack_count - CNT_W'(1);
          current_turn <= head.turn;
          pend_vec     <= win_oh;
          pend_undo    <= undo_rise;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Randomized bench for move_sequencer: a board/turn/history model predicts the
// move and undo pulses produced by each switch or button action.
module tb_move_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  input_switches;
  logic        undo_sig;
  logic [17:0] tiles;
  logic        game_over;
  logic        move_valid;
  logic [8:0]  move_onehot;
  logic        move_turn;
  logic        undo_valid;
  logic [17:0] undo_tiles;
  logic        current_turn;
  logic [4:0]  stack_count;

  move_sequencer #(.DEBOUNCE_CYCLES(4), .STACK_DEPTH(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .input_switches (input_switches),
    .undo_sig       (undo_sig),
    .tiles          (tiles),
    .game_over      (game_over),
    .move_valid     (move_valid),
    .move_onehot    (move_onehot),
    .move_turn      (move_turn),
    .undo_valid     (undo_valid),
    .undo_tiles     (undo_tiles),
    .current_turn   (current_turn),
    .stack_count    (stack_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [8:0] oh; logic turn; } mv_t;
  typedef struct { logic [17:0] b; logic t; } ent_t;

  mv_t         mv_q[$];
  logic [17:0] ud_q[$];
  logic        stray = 1'b0;

  logic [17:0] m_board;
  logic        m_turn;
  logic        m_go;
  ent_t        m_stack[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (move_valid) mv_q.push_back('{oh: move_onehot, turn: move_turn});
      else if (move_onehot != '0) stray = 1'b1;
      if (undo_valid) ud_q.push_back(undo_tiles);
      else if (undo_tiles != '0) stray = 1'b1;
    end
  end

  function automatic int tile_of(input int s);
    int row;
    int col;
    row = s / 3;
    col = s % 3;
    return row * 3 + (2 - col);
  endfunction

  task automatic do_reset();
    reset          = 1'b1;
    input_switches = '0;
    undo_sig       = 1'b0;
    game_over      = 1'b0;
    tiles          = '0;
    m_board        = '0;
    m_turn         = 1'b0;
    m_go           = 1'b0;
    m_stack.delete();
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
  endtask

  // A hold of 6+ cycles is a real press; 1-3 cycles is a glitch that must vanish.
  task automatic act(input logic [8:0] mask, input logic u, input int hold);
    logic        exp_mv;
    logic        exp_ud;
    logic [8:0]  exp_oh;
    logic        exp_turn;
    logic [17:0] exp_ut;
    ent_t        e;
    int          best;
    int          mb;
    int          ub;
    exp_mv = 1'b0; exp_ud = 1'b0; exp_oh = '0; exp_turn = 1'b0; exp_ut = '0;
    mb = mv_q.size();
    ub = ud_q.size();
    if (hold >= 6) begin
      if (u && m_stack.size() > 0) begin
        e = m_stack.pop_back();
        exp_ud = 1'b1; exp_ut = e.b;
        m_board = e.b; m_turn = e.t;
      end else if (mask != '0) begin
        best = -1;
        for (int s = 0; s < 9; s++) if (mask[s] && tile_of(s) > best) best = tile_of(s);
        if (!m_go && m_board[2*best +: 2] == 2'b00) begin
          exp_mv = 1'b1;
          exp_oh = 9'(1) << best;
          exp_turn = m_turn;
          m_stack.push_back('{b: m_board, t: m_turn});
          if (m_stack.size() > 16) void'(m_stack.pop_front());
          m_board[2*best +: 2] = m_turn ? 2'b10 : 2'b01;
          m_turn = ~m_turn;
        end
      end
    end
    input_switches = mask;
    undo_sig       = u;
    repeat (hold) tick();
    input_switches = '0;
    undo_sig       = 1'b0;
    repeat (14) tick();
    check("move_pulses", mv_q.size() - mb, {31'd0, exp_mv});
    if (exp_mv && mv_q.size() > mb) begin
      check("move_onehot", mv_q[mb].oh, exp_oh);
      check("move_turn", mv_q[mb].turn, exp_turn);
    end
    check("undo_pulses", ud_q.size() - ub, {31'd0, exp_ud});
    if (exp_ud && ud_q.size() > ub) check("undo_tiles", ud_q[ub], exp_ut);
    check("current_turn", current_turn, m_turn);
    check("stack_count", stack_count, m_stack.size());
    tiles = m_board;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [8:0] mask;
    int         op;
    reset = 1'b1;
    input_switches = '0; undo_sig = 1'b0; tiles = '0; game_over = 1'b0;
    #2;
    check("rst_move_valid", move_valid, 0);
    check("rst_move_onehot", move_onehot, 0);
    check("rst_move_turn", move_turn, 0);
    check("rst_undo_valid", undo_valid, 0);
    check("rst_undo_tiles", undo_tiles, 0);
    check("rst_current_turn", current_turn, 0);
    check("rst_stack_count", stack_count, 0);
    do_reset();

    act(9'h040, 1'b0, 6);                  // sw6 -> tile 8
    act(9'h010, 1'b0, 2);                  // glitch on sw4
    act(9'h010, 1'b0, 6);
    m_board[1:0] = 2'b01; tiles = m_board;
    act(9'h004, 1'b0, 6);                  // sw2 -> occupied tile 0
    act(9'h101, 1'b0, 6);                  // sw0 + sw8 -> tile 6 wins
    act(9'h000, 1'b1, 6);
    m_go = 1'b1; game_over = 1'b1;
    act(9'h002, 1'b0, 6);
    act(9'h000, 1'b1, 6);
    m_go = 1'b0; game_over = 1'b0;

    for (int i = 0; i < 160; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        act(9'(1) << $urandom_range(0, 8), 1'b0, 6);
      end else if (op == 5) begin
        mask = (9'(1) << $urandom_range(0, 8)) | (9'(1) << $urandom_range(0, 8));
        act(mask, (m_stack.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0, 6);
      end else if (op == 6) begin
        act(9'h000, 1'b1, 6);
      end else if (op == 7) begin
        if ($urandom_range(0, 1) == 0) act(9'(1) << $urandom_range(0, 8), 1'b0, $urandom_range(1, 3));
        else act(9'h000, 1'b1, $urandom_range(1, 3));
      end else if (op == 8) begin
        m_go = ($urandom_range(0, 3) == 0);
        game_over = m_go;
      end else begin
        m_board = '0;
        tiles = '0;
      end
    end

    do_reset();
    for (int i = 0; i < 17; i++) begin
      m_board = '0;
      tiles = '0;
      act(9'(1) << $urandom_range(0, 8), 1'b0, 6);
    end
    check("full_stack_count", stack_count, 16);
    for (int i = 0; i < 17; i++) act(9'h000, 1'b1, 6);

    do_reset();
    input_switches = 9'h001;
    for (int i = 0; i < 30 && !move_valid; i++) tick();
    check("commit_seen", move_valid, 1);
    reset = 1'b1;
    input_switches = '0;
    #1;
    check("abort_move_valid", move_valid, 0);
    check("abort_move_onehot", move_onehot, 0);
    check("abort_undo_valid", undo_valid, 0);
    check("abort_current_turn", current_turn, 0);
    check("abort_stack_count", stack_count, 0);
    do_reset();
    act(9'h100, 1'b0, 6);

    check("stray_outputs", stray, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
